multicycle_sequencer: RTL and testbench

- Single-clock stage sequencer for the multicycle LEGv8 datapath. It replaces the fixed delayed-clock scheme with one clock plus one-hot stage enables.
- It owns the PC register, counts retired instructions, supports a variable-latency memory stage via a ready handshake, and stops on a halt request or a configurable instruction limit.
- It sits at datapath top level and drives the fetch, decode-read, execute, memory and writeback enables.

---
 rtl/multicycle_sequencer_pkg.sv | 19 +
 rtl/multicycle_sequencer_stage_onehot_decoder.sv | 20 ++
 rtl/multicycle_sequencer.sv | 147 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multicycle LEGv8 stage sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALTED   = 2'd3
    } seq_state_e;

    localparam int PC_INCR = 4;

    localparam int STG_FETCH  = 0;
    localparam int STG_DECODE = 1;
    localparam int STG_EXEC   = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

endpackage

// File: rtl/multicycle_sequencer_stage_onehot_decoder.sv
// Turns the registered stage index into a one-hot enable vector, forced to zero when idle.
module stage_onehot_decoder
    import seq_pkg::*;
#(
    parameter int N  = STG_WB + 1,
    parameter int SW = 3
) (
    input  logic [SW-1:0] idx_i,
    input  logic          en_i,
    output logic [N-1:0]  onehot_o
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign onehot_o[gi] = en_i && (idx_i == SW'(gi));
        end
    endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// Single-clock stage sequencer: owns the PC, counts retirements, stalls on memory
// readiness and halts on request or instruction limit.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int              WORD       = 64,
    parameter int              NUM_STAGES = STG_WB + 1,
    parameter int              MEM_STAGE  = STG_MEM,
    parameter int              MEM_WAIT   = 0,
    parameter int              MAX_INSTR  = 50,
    parameter logic [WORD-1:0] RESET_PC   = '0,
    parameter int              CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  mem_ready,
    input  logic                  pc_src,
    input  logic [WORD-1:0]       branch_target,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [WORD-1:0]       pc,
    output logic                  pc_write,
    output logic [CNT_W-1:0]      instr_count,
    output logic                  running,
    output logic                  done
);

    localparam int              SW       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [SW-1:0]   LAST_STG = SW'(NUM_STAGES - 1);
    localparam logic [SW-1:0]   MEM_STG  = SW'(MEM_STAGE);
    localparam int              WAIT_W   = $clog2(MEM_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT);

    seq_state_e        state_q, state_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WORD-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halt_q, halt_d;

    logic              mem_ok;
    logic [WAIT_W-1:0] wait_inc;
    logic [CNT_W-1:0]  cnt_inc;

    // The counter saturates at MEM_WAIT, so equality means "at least MEM_WAIT".
    assign mem_ok   = (wait_q == WAIT_MAX);
    assign wait_inc = mem_ok ? wait_q : wait_q + WAIT_W'(1);
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        wait_d  = wait_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;

        if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && halt_req)
            halt_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    wait_d  = '0;
                end
            end
            ST_RUN: begin
                if (stage_q == MEM_STG) begin
                    if (mem_ok && mem_ready) begin
                        stage_d = stage_q + SW'(1);
                    end else begin
                        state_d = ST_MEM_WAIT;
                        wait_d  = wait_inc;
                    end
                end else if (stage_q == LAST_STG) begin
                    pc_d    = pc_src ? branch_target : pc_q + WORD'(PC_INCR);
                    cnt_d   = cnt_inc;
                    stage_d = '0;
                    if (halt_q || halt_req ||
                        (MAX_INSTR != 0 && cnt_inc == CNT_W'(MAX_INSTR))) begin
                        state_d = ST_HALTED;
                        halt_d  = 1'b0;
                    end
                end else begin
                    stage_d = stage_q + SW'(1);
                    if (stage_q + SW'(1) == MEM_STG)
                        wait_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ok && mem_ready) begin
                    state_d = ST_RUN;
                    stage_d = MEM_STG + SW'(1);
                end else begin
                    wait_d = wait_inc;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    wait_d  = '0;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            wait_q  <= '0;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            wait_q  <= wait_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

    assign running     = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign done        = (state_q == ST_HALTED);
    assign pc_write    = (state_q == ST_RUN) && (stage_q == LAST_STG);
    assign pc          = pc_q;
    assign instr_count = cnt_q;

    stage_onehot_decoder #(
        .N  (NUM_STAGES),
        .SW (SW)
    ) u_stage_dec (
        .idx_i    (stage_q),
        .en_i     (running),
        .onehot_o (stage_en)
    );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: default-parameter sequencer plus a MEM_WAIT=2 / unlimited instance.
module tb_multicycle_sequencer;

    logic        clk;
    logic        reset;

    logic        a_start, a_halt, a_ready, a_src;
    logic [63:0] a_tgt;
    logic [4:0]  a_en;
    logic [63:0] a_pc;
    logic        a_pcw, a_run, a_done;
    logic [31:0] a_cnt;

    logic        b_start, b_halt, b_ready, b_src;
    logic [63:0] b_tgt;
    logic [4:0]  b_en;
    logic [63:0] b_pc;
    logic        b_pcw, b_run, b_done;
    logic [31:0] b_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cyc;

    multicycle_sequencer dut_a (
        .clk           (clk),
        .reset         (reset),
        .start         (a_start),
        .halt_req      (a_halt),
        .mem_ready     (a_ready),
        .pc_src        (a_src),
        .branch_target (a_tgt),
        .stage_en      (a_en),
        .pc            (a_pc),
        .pc_write      (a_pcw),
        .instr_count   (a_cnt),
        .running       (a_run),
        .done          (a_done)
    );

    multicycle_sequencer #(
        .MEM_WAIT  (2),
        .MAX_INSTR (0)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .start         (b_start),
        .halt_req      (b_halt),
        .mem_ready     (b_ready),
        .pc_src        (b_src),
        .branch_target (b_tgt),
        .stage_en      (b_en),
        .pc            (b_pc),
        .pc_write      (b_pcw),
        .instr_count   (b_cnt),
        .running       (b_run),
        .done          (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        a_start = 0; a_halt = 0; a_ready = 0; a_src = 0; a_tgt = '0;
        b_start = 0; b_halt = 0; b_ready = 0; b_src = 0; b_tgt = '0;
        repeat (2) tick();
        chk("rst_en",   64'(a_en),  64'h0);
        chk("rst_pc",   a_pc,       64'h0);
        chk("rst_cnt",  64'(a_cnt), 64'h0);
        chk("rst_run",  64'(a_run), 64'h0);
        chk("rst_done", 64'(a_done), 64'h0);
        chk("rst_pcw",  64'(a_pcw), 64'h0);
        reset = 1'b1;
        tick();

        // MEM_WAIT=2: memory bit held three cycles, seven cycles per instruction
        b_ready = 1; b_start = 1;
        tick();
        b_start = 0;
        chk("b_en0", 64'(b_en), 64'h01);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("b_walk", 64'(b_en), 64'h1 << k);
        end
        repeat (2) begin
            tick();
            chk("b_memhold", 64'(b_en), 64'h08);
        end
        tick();
        chk("b_en_wb", 64'(b_en), 64'h10);
        chk("b_pcw",   64'(b_pcw), 64'h1);
        tick();
        chk("b_pc1",  b_pc, 64'h4);
        chk("b_cnt1", 64'(b_cnt), 64'h1);
        $display("txn b_mem_wait: pc=%0h count=%0d", b_pc, b_cnt);

        // Instruction 1: plain walk through all five stages
        a_ready = 1; a_start = 1;
        tick();
        a_start = 0;
        chk("a_run", 64'(a_run), 64'h1);
        chk("a_en0", 64'(a_en), 64'h01);
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("a_walk", 64'(a_en), 64'h1 << k);
        end
        chk("a_pcw_wb",  64'(a_pcw), 64'h1);
        chk("a_pc_prewb", a_pc, 64'h0);
        tick();
        chk("a_pc1",  a_pc, 64'h4);
        chk("a_cnt1", 64'(a_cnt), 64'h1);
        chk("a_en_i2", 64'(a_en), 64'h01);
        chk("a_pcw_off", 64'(a_pcw), 64'h0);
        $display("txn a_instr1: pc=%0h count=%0d", a_pc, a_cnt);

        // Instruction 2: memory stall, a stray start, then a taken branch
        a_ready = 0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk("a_stall_en", 64'(a_en), 64'h08);
            chk("a_stall_pc", a_pc, 64'h4);
            a_start = (i == 1);
            tick();
        end
        a_start = 0; a_ready = 1;
        chk("a_stall_last", 64'(a_en), 64'h08);
        tick();
        chk("a_resume", 64'(a_en), 64'h10);
        a_src = 1; a_tgt = 64'h100;
        chk("a_pcw2", 64'(a_pcw), 64'h1);
        tick();
        chk("a_branch_pc", a_pc, 64'h100);
        chk("a_cnt2", 64'(a_cnt), 64'h2);
        $display("txn a_instr2: pc=%0h count=%0d", a_pc, a_cnt);

        // Instruction 3 branches to the top of the address space; 4 wraps to zero
        a_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        repeat (5) tick();
        chk("a_pc_top", a_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("a_cnt3", 64'(a_cnt), 64'h3);
        a_tgt = 64'h500;
        repeat (4) tick();
        a_src = 0;
        tick();
        chk("a_pc_wrap", a_pc, 64'h0);
        chk("a_cnt4", 64'(a_cnt), 64'h4);
        $display("txn a_wrap: pc=%0h count=%0d", a_pc, a_cnt);

        // Instruction 5: halt pulsed in decode still retires the instruction
        tick();
        a_halt = 1;
        tick();
        a_halt = 0;
        repeat (2) tick();
        chk("a_nohalt_yet", 64'(a_done), 64'h0);
        chk("a_run_wb", 64'(a_run), 64'h1);
        tick();
        chk("a_done5", 64'(a_done), 64'h1);
        chk("a_en_halt", 64'(a_en), 64'h0);
        chk("a_cnt5", 64'(a_cnt), 64'h5);
        chk("a_pc5", a_pc, 64'h4);
        chk("a_run_halt", 64'(a_run), 64'h0);
        tick();
        chk("a_hold_pc", a_pc, 64'h4);
        chk("a_hold_cnt", 64'(a_cnt), 64'h5);
        $display("txn a_halt5: pc=%0h count=%0d done=%0d", a_pc, a_cnt, a_done);

        // Restart from HALTED, halt in decode of instruction 3
        a_start = 1;
        tick();
        a_start = 0;
        chk("a_rs_pc", a_pc, 64'h0);
        chk("a_rs_cnt", 64'(a_cnt), 64'h0);
        chk("a_rs_run", 64'(a_run), 64'h1);
        chk("a_rs_done", 64'(a_done), 64'h0);
        repeat (10) tick();
        tick();
        a_halt = 1;
        tick();
        a_halt = 0;
        repeat (3) tick();
        chk("a_h3_cnt", 64'(a_cnt), 64'h3);
        chk("a_h3_done", 64'(a_done), 64'h1);
        chk("a_h3_en", 64'(a_en), 64'h0);
        chk("a_h3_pc", a_pc, 64'hC);
        $display("txn a_halt3: pc=%0h count=%0d done=%0d", a_pc, a_cnt, a_done);

        // Instruction limit: 50 instructions x 5 cycles
        a_start = 1;
        tick();
        a_start = 0;
        n_cyc = 0;
        while (a_run === 1'b1 && n_cyc < 400) begin
            n_cyc++;
            tick();
        end
        chk("a_lim_cycles", 64'(n_cyc), 64'd250);
        chk("a_lim_cnt", 64'(a_cnt), 64'd50);
        chk("a_lim_pc", a_pc, 64'd200);
        chk("a_lim_done", 64'(a_done), 64'h1);
        $display("txn a_limit: cycles=%0d pc=%0h count=%0d", n_cyc, a_pc, a_cnt);

        // Asynchronous reset in the execute stage of instruction 2
        a_start = 1;
        tick();
        a_start = 0;
        repeat (7) tick();
        chk("a_pre_rst_en", 64'(a_en), 64'h04);
        chk("a_pre_rst_pc", a_pc, 64'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("a_arst_en", 64'(a_en), 64'h0);
        chk("a_arst_pc", a_pc, 64'h0);
        chk("a_arst_cnt", 64'(a_cnt), 64'h0);
        chk("a_arst_run", 64'(a_run), 64'h0);
        chk("a_arst_done", 64'(a_done), 64'h0);
        chk("b_arst_cnt", 64'(b_cnt), 64'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("a_idle_after", 64'(a_run), 64'h0);
        $display("txn a_async_reset: pc=%0h count=%0d", a_pc, a_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
